ahb2apb_bridge_core: RTL and testbench

- AHB-Lite slave to APB3 master bridge; consumes the transfers the AHB master interface produces and converts each one into a single APB setup/access sequence.
- Sits between the AHB master (HCLK domain) and one APB slave.
- Performs address-range and read-only-region checks before issuing any APB access.
- Returns HRDATA, HREADYOUT and HRESP to the AHB side.

---
 rtl/ahb2apb_bridge_core.sv | 160 ++++++++++++++++
 tb/tb_ahb2apb_bridge_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge_core.sv
`default_nettype none
// ============================================================================
//  Module   : ahb2apb_bridge_core
//  Purpose  : AHB-Lite slave to APB3 master bridge. Every accepted AHB beat
//             becomes one APB setup/access sequence. Out-of-range addresses,
//             writes to the read-only window and oversized transfers are
//             rejected before any APB activity. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb2apb_bridge_core #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int PADDR_SIZE = 10,
    parameter int ADDR_LIMIT = 1024,
    parameter int RO_WORDS   = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    // AHB-Lite slave side
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [HDATA_SIZE-1:0] HRDATA,
    // APB3 master side
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [PADDR_SIZE-1:0] PADDR,
    output logic                  PWRITE,
    output logic [HDATA_SIZE-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [HDATA_SIZE-1:0] PRDATA,
    input  logic                  PSLVERR
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LATCH  = 3'd1;
    localparam logic [2:0] c_ST_SETUP  = 3'd2;
    localparam logic [2:0] c_ST_ACCESS = 3'd3;
    localparam logic [2:0] c_ST_ERR1   = 3'd4;
    localparam logic [2:0] c_ST_ERR2   = 3'd5;

    // Legality limits expressed in the widths they are compared against
    localparam logic [HADDR_SIZE-1:0] c_ADDR_LIMIT = HADDR_SIZE'(ADDR_LIMIT);
    localparam logic [HADDR_SIZE-1:0] c_RO_LIMIT   = HADDR_SIZE'(RO_WORDS * 4);
    localparam logic [2:0]            c_MAX_HSIZE  = 3'($clog2(HDATA_SIZE / 8));

    logic [2:0]            r_state;
    logic [PADDR_SIZE-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;

    logic w_accept;
    logic w_err;

    // A beat is taken only in IDLE; IDLE/BUSY beats fall through as zero-wait OKAY
    assign w_accept = HSEL & HREADY & HTRANS[1] & (r_state == c_ST_IDLE);

    // Reject before any APB access: out of range, read-only write, oversized
    assign w_err = (HADDR >= c_ADDR_LIMIT)
                 | (HWRITE & (HADDR < c_RO_LIMIT))
                 | (HSIZE > c_MAX_HSIZE);

    // Burst type and the SEQ/NONSEQ distinction do not change behaviour;
    // the latched size is kept for visibility only.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, HTRANS[0], HBURST, r_size};

    // Bridge sequencer: drives state, AHB response and APB outputs together
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= c_ST_IDLE;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_size    <= 3'd0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_addr    <= HADDR[PADDR_SIZE-1:0];
                        r_write   <= HWRITE;
                        r_size    <= HSIZE;
                        HREADYOUT <= 1'b0;
                        if (w_err) begin
                            HRESP   <= 1'b1;
                            r_state <= c_ST_ERR1;
                        end else begin
                            r_state <= c_ST_LATCH;
                        end
                    end
                end
                c_ST_LATCH: begin
                    // HWDATA is valid only in the data phase, i.e. now
                    if (r_write) begin
                        PWDATA <= HWDATA;
                    end
                    PSEL    <= 1'b1;
                    PADDR   <= r_addr;
                    PWRITE  <= r_write;
                    r_state <= c_ST_SETUP;
                end
                c_ST_SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= c_ST_ACCESS;
                end
                c_ST_ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            HRESP   <= 1'b1;
                            r_state <= c_ST_ERR1;
                        end else begin
                            if (!r_write) begin
                                HRDATA <= PRDATA;
                            end
                            HREADYOUT <= 1'b1;
                            r_state   <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_ERR1: begin
                    // Second half of the two-cycle ERROR response
                    HREADYOUT <= 1'b1;
                    r_state   <= c_ST_ERR2;
                end
                c_ST_ERR2: begin
                    HRESP   <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_bridge_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb2apb_bridge_core
//  Purpose  : Directed self-checking bench for ahb2apb_bridge_core.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb2apb_bridge_core;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    wire         HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        PSEL;
    logic        PENABLE;
    logic [9:0]  PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    // Single-slave system: the bus ready is the slave's own ready
    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb2apb_bridge_core dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Issue one NONSEQ beat and wait (bounded) for its completion.
    // Returns the number of wait states, HRESP in the first wait cycle,
    // the final HRESP, and whether PSEL was ever seen.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output int nlow, output logic resp_first,
                        output logic resp, output logic psel_seen);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        HSIZE  = size;
        tick();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = wdata;
        nlow = 0;
        psel_seen = 1'b0;
        resp_first = HRESP;
        resp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (HREADYOUT) break;
            nlow++;
            psel_seen |= PSEL;
            tick();
        end
        resp = HRESP;
        if (resp) tick();
    endtask

    int   nlow;
    logic rf, rs, ps;
    int   lows;
    int   acc;

    initial begin
        HRESETn = 1'b0;
        HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2;
        HBURST = 3'd0; HWDATA = '0; PREADY = 1'b1; PRDATA = '0; PSLVERR = 1'b0;
        tick();
        tick();
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hresp",     {31'd0, HRESP},     32'd0);
        check("rst_hrdata",    HRDATA,             32'd0);
        check("rst_psel",      {31'd0, PSEL},      32'd0);
        check("rst_penable",   {31'd0, PENABLE},   32'd0);
        check("rst_paddr",     {22'd0, PADDR},     32'd0);
        check("rst_pwrite",    {31'd0, PWRITE},    32'd0);
        check("rst_pwdata",    PWDATA,             32'd0);
        HRESETn = 1'b1;
        tick();

        // ---- Write 0x010, cycle-by-cycle timing ----
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h010; HWRITE = 1'b1; HSIZE = 3'd2;
        tick();                                          // T+1
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hDEADBEEF;
        check("wr_t1_hreadyout", {31'd0, HREADYOUT}, 32'd0);
        check("wr_t1_psel",      {31'd0, PSEL},      32'd0);
        tick();                                          // T+2
        check("wr_t2_psel",    {31'd0, PSEL},    32'd1);
        check("wr_t2_penable", {31'd0, PENABLE}, 32'd0);
        check("wr_t2_paddr",   {22'd0, PADDR},   32'h010);
        check("wr_t2_pwrite",  {31'd0, PWRITE},  32'd1);
        check("wr_t2_pwdata",  PWDATA,           32'hDEADBEEF);
        tick();                                          // T+3
        check("wr_t3_penable",   {31'd0, PENABLE},   32'd1);
        check("wr_t3_hreadyout", {31'd0, HREADYOUT}, 32'd0);
        tick();                                          // T+4
        check("wr_t4_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("wr_t4_hresp",     {31'd0, HRESP},     32'd0);
        check("wr_t4_psel",      {31'd0, PSEL},      32'd0);
        check("wr_t4_pwdata",    PWDATA,             32'hDEADBEEF);

        // ---- Read 0x020 with two PREADY-low ACCESS cycles ----
        PRDATA = 32'h12345678;
        PREADY = 1'b0;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h020; HWRITE = 1'b0;
        lows = 0;
        acc = 0;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        for (int i = 0; i < 20; i++) begin
            if (HREADYOUT) break;
            lows++;
            if (PENABLE) begin
                acc++;
                if (acc == 3) PREADY = 1'b1;
            end
            tick();
        end
        check("rd_wait_cycles", lows,   32'd5);
        check("rd_hrdata",      HRDATA, 32'h12345678);
        check("rd_hresp",       {31'd0, HRESP}, 32'd0);
        PREADY = 1'b1;

        // ---- Write to read-only word 0x004 ----
        xfer(1'b1, 32'h004, 3'd2, 32'h11111111, nlow, rf, rs, ps);
        check("ro_wr_nlow",   nlow,         32'd1);
        check("ro_wr_err1",   {31'd0, rf},  32'd1);
        check("ro_wr_err2",   {31'd0, rs},  32'd1);
        check("ro_wr_psel",   {31'd0, ps},  32'd0);
        check("ro_wr_idle",   {31'd0, HRESP}, 32'd0);

        // ---- Read of the read-only word is legal ----
        PRDATA = 32'hA5A50004;
        xfer(1'b0, 32'h004, 3'd2, 32'h0, nlow, rf, rs, ps);
        check("ro_rd_nlow",   nlow,        32'd3);
        check("ro_rd_resp",   {31'd0, rs}, 32'd0);
        check("ro_rd_psel",   {31'd0, ps}, 32'd1);
        check("ro_rd_hrdata", HRDATA,      32'hA5A50004);

        // ---- Read out of range 0x400 ----
        xfer(1'b0, 32'h400, 3'd2, 32'h0, nlow, rf, rs, ps);
        check("oor_nlow", nlow,        32'd1);
        check("oor_resp", {31'd0, rs}, 32'd1);
        check("oor_psel", {31'd0, ps}, 32'd0);

        // ---- IDLE and BUSY beats: zero-wait OKAY, no APB ----
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h040;
        tick();
        check("idle_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("idle_hresp",     {31'd0, HRESP},     32'd0);
        HTRANS = 2'b01;
        tick();
        check("busy_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("busy_psel",      {31'd0, PSEL},      32'd0);
        HSEL = 1'b0; HTRANS = 2'b00;

        // ---- Oversized transfer (doubleword on 32-bit bus) ----
        xfer(1'b0, 32'h030, 3'd3, 32'h0, nlow, rf, rs, ps);
        check("size_resp", {31'd0, rs}, 32'd1);
        check("size_psel", {31'd0, ps}, 32'd0);

        // ---- APB slave error on read: HRDATA keeps the old value ----
        PRDATA  = 32'hFFFF0000;
        PSLVERR = 1'b1;
        xfer(1'b0, 32'h050, 3'd2, 32'h0, nlow, rf, rs, ps);
        check("slverr_nlow",   nlow,        32'd4);
        check("slverr_resp",   {31'd0, rs}, 32'd1);
        check("slverr_psel",   {31'd0, ps}, 32'd1);
        check("slverr_hrdata", HRDATA,      32'hA5A50004);
        PSLVERR = 1'b0;

        // ---- Boundaries: first writable word, last legal word ----
        xfer(1'b1, 32'h010, 3'd2, 32'h0BADCAFE, nlow, rf, rs, ps);
        check("bnd_wr_resp",   {31'd0, rs}, 32'd0);
        check("bnd_wr_pwdata", PWDATA,      32'h0BADCAFE);
        PRDATA = 32'h3FC03FC0;
        xfer(1'b0, 32'h3FC, 3'd2, 32'h0, nlow, rf, rs, ps);
        check("bnd_rd_resp",   {31'd0, rs}, 32'd0);
        check("bnd_rd_paddr",  {22'd0, PADDR}, 32'h3FC);
        check("bnd_rd_hrdata", HRDATA,      32'h3FC03FC0);

        // ---- Reset asserted during ACCESS ----
        PREADY = 1'b0;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h060; HWRITE = 1'b1; HSIZE = 3'd2;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h55555555;
        for (int i = 0; i < 10; i++) begin
            if (PENABLE) break;
            tick();
        end
        check("mid_penable_before", {31'd0, PENABLE}, 32'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("mid_rst_psel",      {31'd0, PSEL},      32'd0);
        check("mid_rst_penable",   {31'd0, PENABLE},   32'd0);
        check("mid_rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        tick();
        HRESETn = 1'b1;
        PREADY  = 1'b1;
        tick();
        xfer(1'b1, 32'h08C, 3'd2, 32'hCAFEF00D, nlow, rf, rs, ps);
        check("post_rst_nlow",   nlow,          32'd3);
        check("post_rst_resp",   {31'd0, rs},   32'd0);
        check("post_rst_pwdata", PWDATA,        32'hCAFEF00D);
        check("post_rst_paddr",  {22'd0, PADDR}, 32'h08C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
